rv32i_alu: RTL and testbench

- 32-bit integer ALU for the RV32I datapath; executes the register/immediate arithmetic, logic and shift operations.
- Primary result `res` is purely combinational: zero latency from `opr_a`/`opr_b`/`opcode`.
- A registered copy with a valid flag and a zero flag is provided for pipelined consumers.
- Sits in the execute stage, fed by operand muxes and the decoder's ALU opcode.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/rv32i_alu_shifter.sv | 27 ++
 rtl/rv32i_alu.sv | 65 ++++++
 tb/tb_rv32i_alu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath definitions: datapath width, ALU opcode encoding,
// and a bit-reversal helper used by the barrel shifter.
package rv32i_pkg;

    localparam int DPW = 32;

    // Encodings 8-15 are reserved and produce a zero result.
    typedef enum logic [3:0] {
        ADD_OP = 4'd0,
        SUB_OP = 4'd1,
        SLL_OP = 4'd2,
        SRL_OP = 4'd3,
        SRA_OP = 4'd4,
        XOR_OP = 4'd5,
        OR_OP  = 4'd6,
        AND_OP = 4'd7
    } alu_op_t;

    function automatic logic [DPW-1:0] bit_rev(input logic [DPW-1:0] v);
        logic [DPW-1:0] r;
        r = '0;
        for (int i = 0; i < DPW; i++) r[i] = v[DPW-1-i];
        return r;
    endfunction

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Five-stage log barrel shifter. Left shifts reuse the right-shift network
// by reversing the operand on the way in and the result on the way out.
module rv32i_alu_shifter
    import rv32i_pkg::*;
(
    input  logic [DPW-1:0] din,
    input  logic [4:0]     shamt,
    input  logic           left,
    input  logic           arith,
    output logic [DPW-1:0] dout
);

    logic [5:0][DPW-1:0] stg;
    logic                fill;

    // Sign fill only applies to right shifts; left shifts always shift in zeros.
    assign fill   = arith & ~left & din[DPW-1];
    assign stg[0] = left ? bit_rev(din) : din;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int SH = 1 << i;
        assign stg[i+1] = shamt[i] ? {{SH{fill}}, stg[i][DPW-1:SH]} : stg[i];
    end

    assign dout = left ? bit_rev(stg[5]) : stg[5];

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result/zero plus a one-cycle
// registered copy qualified by in_valid.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           arst_n,
    input  logic [DPW-1:0] opr_a,
    input  logic [DPW-1:0] opr_b,
    input  alu_op_t        opcode,
    input  logic           in_valid,
    output logic [DPW-1:0] res,
    output logic           zero,
    output logic [DPW-1:0] res_q,
    output logic           zero_q,
    output logic           out_valid
);

    logic           is_sub;
    logic [DPW-1:0] addend;
    logic [DPW-1:0] sum;
    logic [DPW-1:0] sh_out;

    // Single adder: subtraction is a + ~b + 1.
    assign is_sub = (opcode == SUB_OP);
    assign addend = is_sub ? ~opr_b : opr_b;
    assign sum    = opr_a + addend + {{(DPW-1){1'b0}}, is_sub};

    rv32i_alu_shifter u_shifter (
        .din   (opr_a),
        .shamt (opr_b[4:0]),
        .left  (opcode == SLL_OP),
        .arith (opcode == SRA_OP),
        .dout  (sh_out)
    );

    always_comb begin
        res = '0;
        case (opcode)
            ADD_OP, SUB_OP:         res = sum;
            SLL_OP, SRL_OP, SRA_OP: res = sh_out;
            XOR_OP:                 res = opr_a ^ opr_b;
            OR_OP:                  res = opr_a | opr_b;
            AND_OP:                 res = opr_a & opr_b;
            default:                res = '0;
        endcase
    end

    assign zero = (res == '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            res_q     <= '0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q  <= res;
                zero_q <= zero;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vectors, async reset, and
// random traffic against a plain-arithmetic reference model.
module tb_rv32i_alu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] opr_a, opr_b;
    alu_op_t     opcode;
    logic        in_valid;
    logic [31:0] res, res_q;
    logic        zero, zero_q, out_valid;

    int tests = 0;
    int fails = 0;

    rv32i_alu dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .res       (res),
        .zero      (zero),
        .res_q     (res_q),
        .zero_q    (zero_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return a >> sh;
            4'd4:    return 32'($signed(a) >>> sh);
            4'd5:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic v);
        opcode   = alu_op_t'(op);
        opr_a    = a;
        opr_b    = b;
        in_valid = v;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        drive(4'd0, 32'h1234_5678, 32'h1, 1'b1);
        @(posedge clk); #1;
        tests++;
        if ({res_q, zero_q, out_valid} !== 34'h0) begin
            fails++;
            $display("FAIL reset_state res_q=%h zero_q=%b out_valid=%b, want 0/0/0",
                     res_q, zero_q, out_valid);
        end
        tests++;
        if (res !== 32'h1234_5679) begin
            fails++;
            $display("FAIL comb_during_reset res=%h, want 12345679", res);
        end
        @(negedge clk);
        arst_n   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_wrap;
        drive(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        #1;
        tests++;
        if (res !== 32'h0 || zero !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap res=%h zero=%b, want 00000000/1", res, zero);
        end
        @(posedge clk); #1;
        tests++;
        if (res_q !== 32'h0 || zero_q !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap_reg res_q=%h zero_q=%b out_valid=%b, want 0/1/1",
                     res_q, zero_q, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_sub_logic;
        logic [3:0]  ops [4] = '{4'd1, 4'd7, 4'd6, 4'd5};
        logic [31:0] as  [4] = '{32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        logic [31:0] bs  [4] = '{32'h1, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            #1;
            tests++;
            if (res !== exp[i] || zero !== 1'b0) begin
                fails++;
                $display("FAIL sub_logic[%0d] res=%h zero=%b, want %h/0", i, res, zero, exp[i]);
            end
        end
    endtask

    task automatic test_shifts;
        logic [3:0]  ops [6] = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd3, 4'd4};
        logic [31:0] as  [6] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hDEAD_BEEF,
                                 32'hDEAD_BEEF, 32'h8765_4321};
        logic [31:0] bs  [6] = '{32'hFFFF_FFE4, 32'hFFFF_FFE4, 32'd31, 32'hFFFF_FFE0,
                                 32'h0000_0020, 32'h0000_0000};
        logic [31:0] exp [6] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                                 32'hDEAD_BEEF, 32'h8765_4321};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            #1;
            tests++;
            if (res !== exp[i]) begin
                fails++;
                $display("FAIL shift[%0d] res=%h, want %h", i, res, exp[i]);
            end
        end
    endtask

    task automatic test_reserved;
        for (int op = 8; op < 16; op++) begin
            drive(4'(op), $urandom | 32'h1, $urandom, 1'b0);
            #1;
            tests++;
            if (res !== 32'h0 || zero !== 1'b1) begin
                fails++;
                $display("FAIL reserved_op%0d res=%h zero=%b, want 0/1", op, res, zero);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(4'd6, 32'h0000_0F00, 32'h0000_0001, 1'b1);
        @(posedge clk); #1;
        tests++;
        if (res_q !== 32'h0000_0F01 || out_valid !== 1'b1 || zero_q !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset res_q=%h out_valid=%b zero_q=%b, want 00000f01/1/0",
                     res_q, out_valid, zero_q);
        end
        #2 arst_n = 1'b0;
        #1;
        tests++;
        if (res_q !== 32'h0 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset res_q=%h zero_q=%b out_valid=%b, want 0/0/0",
                     res_q, zero_q, out_valid);
        end
        @(negedge clk);
        arst_n   = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (res_q !== 32'h0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_hold res_q=%h out_valid=%b, want 0/0", res_q, out_valid);
        end
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if (i % 16 == 0) b = a;
            drive(op, a, b, 1'b0);
            exp = ref_alu(op, a, b);
            #1;
            tests++;
            if (res !== exp || zero !== (exp == 32'h0)) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h res=%h zero=%b, want %h", i, op, a, b,
                         res, zero, exp);
            end
        end
    endtask

    // Random in_valid traffic: registered outputs must track the last valid result.
    task automatic test_back_to_back;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] exp_q;
        logic        exp_z, exp_v;
        exp_q = res_q;
        exp_z = zero_q;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            drive(op, a, b, 1'($urandom_range(0, 1)));
            exp_v = in_valid;
            if (in_valid) begin
                exp_q = ref_alu(op, a, b);
                exp_z = (exp_q == 32'h0);
            end
            @(posedge clk); #1;
            tests++;
            if (res_q !== exp_q || zero_q !== exp_z || out_valid !== exp_v) begin
                fails++;
                $display("FAIL b2b[%0d] res_q=%h zero_q=%b out_valid=%b, want %h/%b/%b", i,
                         res_q, zero_q, out_valid, exp_q, exp_z, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_logic();
        test_shifts();
        test_reserved();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
